// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends a Schmidl-Cox training symbol (cyclic prefix + two identical halves read from a
// config-written RAM) to every payload frame of a complex-sample AXI-Stream.
module schmidl_cox_preamble_inserter #(
  parameter int FFT_SIZE = 1024,
  parameter int CP_LEN   = 0,
  localparam int HALF_FFT_SIZE = FFT_SIZE / 2,
  localparam int AW = $clog2(HALF_FFT_SIZE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_data,
  input  logic          bypass,
  output logic          busy,
  input  logic [31:0]   i_tdata,
  input  logic          i_tlast,
  input  logic          i_tvalid,
  output logic          i_tready,
  output logic [31:0]   o_tdata,
  output logic          o_tlast,
  output logic          o_tvalid,
  input  logic          o_tready
);

  localparam int TOTAL = CP_LEN + FFT_SIZE;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, PRE, PAY} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     ram [HALF_FFT_SIZE];
  logic [AW-1:0]   pre_addr;
  logic            load;

  // Handshake: a beat transfers on a rising edge where valid && ready; the output register
  // takes a new beat whenever it is empty or its current beat is leaving (load).
  assign load     = !o_tvalid || o_tready;
  assign i_tready = (state == PAY) && load;
  assign busy     = (state != IDLE);

  // Half-size is a power of two, so (cnt - CP_LEN) mod HALF walks HALF-CP..HALF-1 then 0..HALF-1 twice.
  assign pre_addr = cnt[AW-1:0] - AW'(CP_LEN);

  always_ff @(posedge clk) begin
    if (reset_n && !clear && cfg_we && state == IDLE) begin
      ram[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_tready) o_tvalid <= 1'b0;
          if (i_tvalid) begin
            state <= bypass ? PAY : PRE;
            cnt   <= '0;
          end
        end
        PRE: begin
          // Leave PRE as soon as the last preamble beat enters the output register so the
          // first payload beat can follow it without a bubble.
          if (load) begin
            o_tvalid <= 1'b1;
            o_tlast  <= 1'b0;
            o_tdata  <= ram[pre_addr];
            cnt      <= cnt + 1'b1;
            if (cnt == CW'(TOTAL - 1)) state <= PAY;
          end
        end
        PAY: begin
          if (load) begin
            o_tvalid <= i_tvalid;
            if (i_tvalid) begin
              o_tdata <= i_tdata;
              o_tlast <= i_tlast;
              if (i_tlast) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Bench for schmidl_cox_preamble_inserter with FFT_SIZE=8, CP_LEN=2, RAM[k]=0x10+k.
module tb_schmidl_cox_preamble_inserter;

  localparam int FFT_SIZE = 8;
  localparam int CP_LEN   = 2;
  localparam int HALF     = 4;
  localparam int AW       = 2;
  localparam int TOTAL    = 10;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_data;
  logic          bypass;
  logic          busy;
  logic [31:0]   i_tdata;
  logic          i_tlast;
  logic          i_tvalid;
  logic          i_tready;
  logic [31:0]   o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q[$];
  logic [31:0] ram_m [HALF];
  int          pre_addr [TOTAL] = '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
  logic        mon_en   = 1'b0;
  int          rdy_mode = 0;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        il;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eir;
    logic        eb;
  } vec_t;
  vec_t tbl [17];

  schmidl_cox_preamble_inserter #(.FFT_SIZE(FFT_SIZE), .CP_LEN(CP_LEN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .bypass   (bypass),
    .busy     (busy),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // downstream ready: mode 0 always ready, mode 1 repeats 1,0,0
  initial begin
    int ph;
    ph = 0;
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        o_tready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        o_tready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: output beats against exp_q, plus hold-stability under backpressure
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat  = '0;
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (prev_stall) begin
        check("hold_valid", {63'd0, o_tvalid}, 64'd1);
        check("hold_beat", {31'd0, o_tlast, o_tdata}, {31'd0, prev_beat});
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_extra: got beat %h expected no beat", {o_tlast, o_tdata});
        end else begin
          check("out_beat", {31'd0, o_tlast, o_tdata}, {31'd0, exp_q.pop_front()});
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = {o_tlast, o_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      int   guard;
      logic done;
      guard = 0;
      done  = 1'b0;
      i_tvalid = 1'b1;
      i_tdata  = base + k;
      i_tlast  = (k == n - 1);
      while (!done) begin
        @(negedge clk);
        done = i_tready;
        @(posedge clk);
        #1;
        guard++;
        if (!done && guard > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: got no i_tready expected accept of beat %0d", k);
          i_tvalid = 1'b0;
          i_tlast  = 1'b0;
          return;
        end
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic push_pre(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b0, ram_m[pre_addr[k]]});
  endtask

  task automatic push_pay(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), base + k});
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy && !o_tvalid;
    end
    check(name, {63'd0, done}, 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int r, input logic iv, input logic [31:0] id, input logic il,
                         input logic ev, input logic [31:0] ed, input logic el,
                         input logic eir, input logic eb);
    tbl[r] = '{iv: iv, id: id, il: il, ev: ev, ed: ed, el: el, eir: eir, eb: eb};
  endtask

  initial begin
    clear    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    bypass   = 1'b0;
    i_tvalid = 1'b0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    reset_n  = 1'b1;

    // reset values while reset is held
    #3 reset_n = 1'b0;
    #1;
    check("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    check("rst_o_tlast", {63'd0, o_tlast}, 64'd0);
    check("rst_o_tdata", {32'd0, o_tdata}, 64'd0);
    check("rst_i_tready", {63'd0, i_tready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < HALF; k++) begin
      ram_m[k] = 32'h10 + k;
      cfg_write(AW'(k), ram_m[k]);
    end

    // frame A0..A3 cycle by cycle with o_tready=1
    set_vec(0, 1, 32'hA000_0000, 0, 0, 32'h0, 0, 0, 0);
    set_vec(1, 1, 32'hA000_0000, 0, 0, 32'h0, 0, 0, 1);
    for (int r = 2; r <= 10; r++)
      set_vec(r, 1, 32'hA000_0000, 0, 1, ram_m[pre_addr[r-2]], 0, 0, 1);
    set_vec(11, 1, 32'hA000_0000, 0, 1, ram_m[pre_addr[9]], 0, 1, 1);
    set_vec(12, 1, 32'hA000_0001, 0, 1, 32'hA000_0000, 0, 1, 1);
    set_vec(13, 1, 32'hA000_0002, 0, 1, 32'hA000_0001, 0, 1, 1);
    set_vec(14, 1, 32'hA000_0003, 1, 1, 32'hA000_0002, 0, 1, 1);
    set_vec(15, 0, 32'h0, 0, 1, 32'hA000_0003, 1, 0, 0);
    set_vec(16, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    for (int r = 0; r < 17; r++) begin
      i_tvalid = tbl[r].iv;
      i_tdata  = tbl[r].id;
      i_tlast  = tbl[r].il;
      @(negedge clk);
      check($sformatf("t1_valid[%0d]", r), {63'd0, o_tvalid}, {63'd0, tbl[r].ev});
      check($sformatf("t1_irdy[%0d]", r), {63'd0, i_tready}, {63'd0, tbl[r].eir});
      check($sformatf("t1_busy[%0d]", r), {63'd0, busy}, {63'd0, tbl[r].eb});
      if (tbl[r].ev) begin
        check($sformatf("t1_data[%0d]", r), {32'd0, o_tdata}, {32'd0, tbl[r].ed});
        check($sformatf("t1_last[%0d]", r), {63'd0, o_tlast}, {63'd0, tbl[r].el});
      end
      @(posedge clk);
      #1;
    end
    mon_en = 1'b1;

    // same frame under 1,0,0 backpressure
    rdy_mode = 1;
    push_pre(TOTAL);
    push_pay(4, 32'hA000_0000);
    send_frame(4, 32'hA000_0000);
    wait_drain("t2_drain");
    rdy_mode = 0;

    // bypass
    bypass = 1'b1;
    push_pay(3, 32'hB000_0000);
    send_frame(3, 32'hB000_0000);
    wait_drain("t3_drain");
    bypass = 1'b0;

    // config write during PRE is dropped
    push_pre(TOTAL);
    push_pay(2, 32'hC000_0000);
    fork
      send_frame(2, 32'hC000_0000);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("t4_in_pre", {63'd0, busy}, 64'd1);
        cfg_write(2'd1, 32'hDEAD_BEEF);
      end
    join
    wait_drain("t4_drain_a");
    push_pre(TOTAL);
    push_pay(1, 32'hD000_0000);
    send_frame(1, 32'hD000_0000);
    wait_drain("t4_drain_b");

    // config write in IDLE lands at positions 4 and 8
    cfg_write(2'd1, 32'hDEAD_BEEF);
    ram_m[1] = 32'hDEAD_BEEF;
    push_pre(TOTAL);
    push_pay(2, 32'hE000_0000);
    send_frame(2, 32'hE000_0000);
    wait_drain("t4_drain_c");

    // write coincident with IDLE->PRE is visible to the first read
    ram_m[1] = 32'h5555_1111;
    push_pre(TOTAL);
    push_pay(1, 32'hF000_0000);
    fork
      send_frame(1, 32'hF000_0000);
      cfg_write(2'd1, 32'h5555_1111);
    join
    wait_drain("t4_drain_d");
    cfg_write(2'd1, 32'h11);
    ram_m[1] = 32'h11;

    // clear after 5 preamble beats
    begin
      int   cnt;
      int   guard;
      cnt   = 0;
      guard = 0;
      push_pre(6);
      i_tvalid = 1'b1;
      i_tdata  = 32'h7000_0000;
      i_tlast  = 1'b0;
      while (cnt < 5 && guard < 100) begin
        @(negedge clk);
        if (o_tvalid && o_tready) cnt++;
        @(posedge clk);
        #1;
        guard++;
      end
      check("t5_five_beats", 64'(cnt), 64'd5);
      clear    = 1'b1;
      i_tvalid = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("t5_valid", {63'd0, o_tvalid}, 64'd0);
      check("t5_busy", {63'd0, busy}, 64'd0);
      check("t5_irdy", {63'd0, i_tready}, 64'd0);
      check("t5_q_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    push_pre(TOTAL);
    push_pay(1, 32'h7100_0000);
    send_frame(1, 32'h7100_0000);
    wait_drain("t5_drain");

    // asynchronous reset mid-payload
    begin
      logic hit;
      int   guard;
      hit   = 1'b0;
      guard = 0;
      push_pre(TOTAL);
      i_tvalid = 1'b1;
      i_tdata  = 32'h8000_0000;
      i_tlast  = 1'b0;
      while (!hit && guard < 100) begin
        @(negedge clk);
        hit = i_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      check("t6_in_pay", {63'd0, o_tvalid}, 64'd1);
      check("t6_pay_beat", {32'd0, o_tdata}, {32'd0, 32'h8000_0000});
      #2;
      reset_n  = 1'b0;
      i_tvalid = 1'b0;
      #1;
      check("t6_valid", {63'd0, o_tvalid}, 64'd0);
      check("t6_irdy", {63'd0, i_tready}, 64'd0);
      check("t6_busy", {63'd0, busy}, 64'd0);
      check("t6_q_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
    end
    push_pre(TOTAL);
    push_pay(2, 32'h8100_0000);
    send_frame(2, 32'h8100_0000);
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
